mem_test_gen: RTL and testbench

- Parametrised successor to the single-pattern PL-side DDR tester.
- Writes a programmable word region of PS DDR, reads it back and compares it, using the 10-bit burst request interface that feeds the AXI HP master.
- Adds selectable data patterns, runtime region and burst sizing, single-pass or continuous looping, a saturating error counter and a loop counter.
- Instantiated in the top level between the AXI master and the status/debug logic.

---
 rtl/mem_test_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_test_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_test_gen.sv
// Write/read-back DDR region tester: patterned writes, read compare, looping, error/loop counters.
// Define MEM_TEST_ERR_CAPTURE_EN to add first-mismatch capture outputs err_addr/err_exp/err_got.
module mem_test_gen #(
  parameter int          MEM_DATA_BITS = 64,
  parameter int          ADDR_BITS     = 27,
  parameter int          MAX_BURST     = 256,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     continuous,
  input  logic [1:0]               mode,
  input  logic [ADDR_BITS-1:0]     region_base,
  input  logic [ADDR_BITS-1:0]     region_words,
  input  logic [9:0]               burst_words,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              loop_cnt,
  output logic [31:0]              err_cnt,
  output logic                     error,
  output logic                     wr_burst_req,
  output logic                     rd_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [9:0]               rd_burst_len,
  output logic [31:0]              wr_burst_addr,
  output logic [31:0]              rd_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  input  logic                     rd_burst_finish,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data
`ifdef MEM_TEST_ERR_CAPTURE_EN
  ,output logic [31:0]              err_addr
  ,output logic [MEM_DATA_BITS-1:0] err_exp
  ,output logic [MEM_DATA_BITS-1:0] err_got
`endif
);
  localparam int          DW   = MEM_DATA_BITS;
  localparam int          AW   = ADDR_BITS;
  localparam int          REP  = DW / 32;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {IDLE, W_REQ, W_WAIT, R_REQ, R_WAIT, CHECK_END, DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [DW-1:0] pat(input logic [1:0] m, input logic [AW-1:0] a,
                                        input logic [31:0] l);
    logic [31:0] a32;
    a32 = 32'(a);
    case (m)
      2'd0:    return {REP{a32}};
      2'd1:    return {REP{~a32}};
      2'd2:    return DW'(1) << (a32 % 32'(DW));
      default: return {REP{l}};
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [AW-1:0]  base_q, base_d, words_q, words_d, ptr_q, ptr_d, rem_q, rem_d;
  logic [AW-1:0]  wa_q, wa_d, ra_q, ra_d;
  logic [9:0]     blen_q, blen_d, len_q, len_d, rd_cnt_q, rd_cnt_d;
  logic [1:0]     mode_q, mode_d;
  logic           cont_q, cont_d, stop_pend_q, stop_pend_d;
  logic           wr_req_q, wr_req_d, rd_req_q, rd_req_d, error_q, error_d;
  logic [31:0]    wlfsr_q, wlfsr_d, rlfsr_q, rlfsr_d, err_cnt_q, err_cnt_d;
  logic [15:0]    loop_q, loop_d;

  logic [AW-1:0]  words_in, rem_left, ptr_nx;
  logic [9:0]     blen_in, cur_len;
  logic [DW-1:0]  exp_rd;
  logic           rd_mis, stop_now;
  logic [10:0]    rd_seen, missing, err_add;
  logic [32:0]    err_sum;
`ifdef MEM_TEST_ERR_CAPTURE_EN
  logic [31:0]    eaddr_q, eaddr_d;
  logic [DW-1:0]  eexp_q, eexp_d, egot_q, egot_d;
  logic [AW-1:0]  miss_addr;
  logic [DW-1:0]  miss_exp;
  // First missing word sits one past a word that arrives in the finish cycle.
  assign miss_addr = rd_burst_data_valid ? ra_q + AW'(1) : ra_q;
  assign miss_exp  = rd_burst_data_valid ? pat(mode_q, ra_q + AW'(1), lfsr_step(rlfsr_q))
                                         : exp_rd;
`endif

  assign words_in = (region_words == '0) ? AW'(1) : region_words;
  assign blen_in  = (burst_words == 10'd0) ? 10'd1 :
                    (burst_words > 10'(MAX_BURST)) ? 10'(MAX_BURST) : burst_words;
  assign cur_len  = (rem_q < AW'(blen_q)) ? rem_q[9:0] : blen_q;
  assign rem_left = rem_q - AW'(len_q);
  assign ptr_nx   = ptr_q + AW'(len_q);
  assign exp_rd   = pat(mode_q, ra_q, rlfsr_q);
  assign rd_mis   = rd_burst_data_valid && (rd_burst_data != exp_rd);
  assign rd_seen  = 11'(rd_cnt_q) + 11'(rd_burst_data_valid);
  assign missing  = (rd_seen >= 11'(len_q)) ? 11'd0 : 11'(len_q) - rd_seen;
  assign err_add  = 11'(rd_mis) + (rd_burst_finish ? missing : 11'd0);
  assign err_sum  = {1'b0, err_cnt_q} + 33'(err_add);
  assign stop_now = stop_pend_q | stop;

  always_comb begin
    state_d = state_q;   base_d = base_q;     words_d = words_q;   ptr_d = ptr_q;
    rem_d = rem_q;       wa_d = wa_q;         ra_d = ra_q;         blen_d = blen_q;
    len_d = len_q;       rd_cnt_d = rd_cnt_q; mode_d = mode_q;     cont_d = cont_q;
    wr_req_d = wr_req_q; rd_req_d = rd_req_q; error_d = error_q;   wlfsr_d = wlfsr_q;
    rlfsr_d = rlfsr_q;   err_cnt_d = err_cnt_q; loop_d = loop_q;
    stop_pend_d = stop_now;
`ifdef MEM_TEST_ERR_CAPTURE_EN
    eaddr_d = eaddr_q;   eexp_d = eexp_q;     egot_d = egot_q;
`endif
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          base_d = region_base;  words_d = words_in;  blen_d = blen_in;
          mode_d = mode;         cont_d = continuous;
          err_cnt_d = '0;        error_d = 1'b0;      loop_d = '0;
          ptr_d = region_base;   rem_d = words_in;    wlfsr_d = LFSR_SEED;
`ifdef MEM_TEST_ERR_CAPTURE_EN
          eaddr_d = '0;          eexp_d = '0;         egot_d = '0;
`endif
          state_d = W_REQ;
        end
      end
      W_REQ: begin
        len_d = cur_len;  wr_req_d = 1'b1;  wa_d = ptr_q;  state_d = W_WAIT;
      end
      W_WAIT: begin
        if (wr_burst_data_req) begin
          wa_d = wa_q + AW'(1);  wlfsr_d = lfsr_step(wlfsr_q);
        end
        if (wr_burst_finish) begin
          wr_req_d = 1'b0;  ptr_d = ptr_nx;  rem_d = rem_left;
          if (stop_now) state_d = IDLE;
          else if (rem_left == '0) begin
            ptr_d = base_q;  rem_d = words_q;  rlfsr_d = LFSR_SEED;  state_d = R_REQ;
          end else state_d = W_REQ;
        end
      end
      R_REQ: begin
        len_d = cur_len;  rd_req_d = 1'b1;  ra_d = ptr_q;  rd_cnt_d = '0;  state_d = R_WAIT;
      end
      R_WAIT: begin
        if (rd_burst_data_valid) begin
          ra_d = ra_q + AW'(1);  rlfsr_d = lfsr_step(rlfsr_q);  rd_cnt_d = rd_cnt_q + 10'd1;
        end
        if (err_add != 11'd0) begin
          err_cnt_d = err_sum[32] ? '1 : err_sum[31:0];
          error_d   = 1'b1;
`ifdef MEM_TEST_ERR_CAPTURE_EN
          if (!error_q) begin
            if (rd_mis) begin
              eaddr_d = 32'(ra_q);  eexp_d = exp_rd;  egot_d = rd_burst_data;
            end else begin
              eaddr_d = 32'(miss_addr);  eexp_d = miss_exp;  egot_d = '0;
            end
          end
`endif
        end
        if (rd_burst_finish) begin
          rd_req_d = 1'b0;  ptr_d = ptr_nx;  rem_d = rem_left;
          if (stop_now) state_d = IDLE;
          else if (rem_left == '0) state_d = CHECK_END;
          else state_d = R_REQ;
        end
      end
      CHECK_END: begin
        loop_d = loop_q + 16'd1;
        if (cont_q && !stop_now) begin
          ptr_d = base_q;  rem_d = words_q;  wlfsr_d = LFSR_SEED;  state_d = W_REQ;
        end else state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;  base_q <= '0;   words_q <= '0;  ptr_q <= '0;  rem_q <= '0;
      wa_q <= '0;       ra_q <= '0;     blen_q <= '0;   len_q <= '0;  rd_cnt_q <= '0;
      mode_q <= '0;     cont_q <= 1'b0; wr_req_q <= 1'b0; rd_req_q <= 1'b0;
      error_q <= 1'b0;  wlfsr_q <= LFSR_SEED;  rlfsr_q <= LFSR_SEED;
      err_cnt_q <= '0;  loop_q <= '0;   stop_pend_q <= 1'b0;
`ifdef MEM_TEST_ERR_CAPTURE_EN
      eaddr_q <= '0;    eexp_q <= '0;   egot_q <= '0;
`endif
    end else begin
      state_q <= state_d;  base_q <= base_d;   words_q <= words_d;  ptr_q <= ptr_d;
      rem_q <= rem_d;      wa_q <= wa_d;       ra_q <= ra_d;        blen_q <= blen_d;
      len_q <= len_d;      rd_cnt_q <= rd_cnt_d; mode_q <= mode_d;  cont_q <= cont_d;
      wr_req_q <= wr_req_d; rd_req_q <= rd_req_d; error_q <= error_d;
      wlfsr_q <= wlfsr_d;  rlfsr_q <= rlfsr_d; err_cnt_q <= err_cnt_d; loop_q <= loop_d;
      stop_pend_q <= stop_pend_d;
`ifdef MEM_TEST_ERR_CAPTURE_EN
      eaddr_q <= eaddr_d;  eexp_q <= eexp_d;   egot_q <= egot_d;
`endif
    end
  end

  assign busy          = !(state_q inside {IDLE, DONE});
  assign done          = (state_q == DONE);
  assign loop_cnt      = loop_q;
  assign err_cnt       = err_cnt_q;
  assign error         = error_q;
  assign wr_burst_req  = wr_req_q;
  assign rd_burst_req  = rd_req_q;
  assign wr_burst_len  = len_q;
  assign rd_burst_len  = len_q;
  assign wr_burst_addr = 32'(ptr_q);
  assign rd_burst_addr = 32'(ptr_q);
  assign wr_burst_data = pat(mode_q, wa_q, wlfsr_q);
`ifdef MEM_TEST_ERR_CAPTURE_EN
  assign err_addr      = eaddr_q;
  assign err_exp       = eexp_q;
  assign err_got       = egot_q;
`endif
endmodule

// File: tb/tb_mem_test_gen.sv
// Bench for mem_test_gen: table-driven passes, reset-mid-burst sequence and random configs
// against a word-level pattern model and a memory-backed slave.
module tb_mem_test_gen;
  localparam int          AW   = 27;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic        start = 0, stop = 0, continuous = 0;
  logic [1:0]  mode = 0;
  logic [26:0] region_base = 0, region_words = 0;
  logic [9:0]  burst_words = 0;
  logic        busy, done, error, wr_burst_req, rd_burst_req;
  logic [15:0] loop_cnt;
  logic [31:0] err_cnt, wr_burst_addr, rd_burst_addr;
  logic [9:0]  wr_burst_len, rd_burst_len;
  logic        wr_burst_data_req = 0, wr_burst_finish = 0, rd_burst_finish = 0;
  logic        rd_burst_data_valid = 0;
  logic [63:0] wr_burst_data, rd_burst_data = 0;
`ifdef MEM_TEST_ERR_CAPTURE_EN
  logic [31:0] err_addr;
  logic [63:0] err_exp, err_got;
`endif

  mem_test_gen dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .stop(stop), .continuous(continuous),
    .mode(mode), .region_base(region_base), .region_words(region_words),
    .burst_words(burst_words), .busy(busy), .done(done), .loop_cnt(loop_cnt),
    .err_cnt(err_cnt), .error(error), .wr_burst_req(wr_burst_req),
    .rd_burst_req(rd_burst_req), .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
    .wr_burst_addr(wr_burst_addr), .rd_burst_addr(rd_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish), .rd_burst_finish(rd_burst_finish),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data)
`ifdef MEM_TEST_ERR_CAPTURE_EN
    , .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int mode; logic [26:0] base; int words; int burst; int cont;
    int flip; int short_n; int stop_rd;
    int exp_nb; int exp_err; int exp_loop; int exp_done;
  } vec_t;

  int n_pass = 0, n_chk = 0;
  int nw, nr, bad_burst, bad_wdata, dones;
  bit ok;
  logic [63:0] mem [int unsigned];
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // x^32+x^22+x^2+x+1, bit shifted out feeds back into the tap positions
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic o;
    o = s[0];
    s = s >> 1;
    if (o) begin s[31] = ~s[31]; s[21] = ~s[21]; s[1] = ~s[1]; s[0] = ~s[0]; end
    return s;
  endfunction

  function automatic logic [63:0] model_word(input int m, input int idx, input logic [26:0] base);
    longint unsigned a;
    logic [31:0] a32, s;
    a   = (longint'(base) + longint'(idx)) % (64'd1 << AW);
    a32 = 32'(a);
    if (m == 0) return {a32, a32};
    if (m == 1) return {~a32, ~a32};
    if (m == 2) return 64'd1 << (a % 64);
    s = SEED;
    for (int k = 0; k < idx; k++) s = lfsr_next(s);
    return {s, s};
  endfunction

  task automatic run_pass(input vec_t v);
    int ew, eb, wi, ri, n, off;
    logic [31:0] addr, exp_addr;
    logic [9:0] len;
    logic [63:0] d;
    int unsigned key;
    mem.delete();
    nw = 0; nr = 0; bad_burst = 0; bad_wdata = 0; dones = 0; ok = 0;
    ew = (v.words == 0) ? 1 : v.words;
    eb = (v.burst == 0) ? 1 : ((v.burst > 256) ? 256 : v.burst);
    @(negedge ACLK);
    mode = 2'(v.mode); region_base = v.base; region_words = 27'(v.words);
    burst_words = 10'(v.burst); continuous = (v.cont != 0); start = 1;
    @(negedge ACLK);
    start = 0; wi = 0; ri = 0;
    for (int c = 0; c < 20000; c++) begin
      if (done) dones++;
      if (!busy && !done) begin ok = 1; break; end
      if (wr_burst_req) begin
        addr = wr_burst_addr; len = wr_burst_len; off = wi % ew;
        exp_addr = 32'((longint'(v.base) + off) % (64'd1 << AW));
        if (addr != exp_addr || int'(len) != ((ew - off < eb) ? ew - off : eb)) bad_burst++;
        for (int i = 0; i < int'(len); i++) begin
          d = wr_burst_data;
          if (d !== model_word(v.mode, wi % ew, v.base)) bad_wdata++;
          mem[(addr + 32'(i)) & 32'h07FF_FFFF] = d;
          wr_burst_data_req = 1;
          @(negedge ACLK);
          wi++;
        end
        wr_burst_data_req = 0; wr_burst_finish = 1;
        @(negedge ACLK);
        wr_burst_finish = 0; nw++;
      end else if (rd_burst_req) begin
        addr = rd_burst_addr; len = rd_burst_len; off = ri % ew;
        exp_addr = 32'((longint'(v.base) + off) % (64'd1 << AW));
        if (addr != exp_addr || int'(len) != ((ew - off < eb) ? ew - off : eb)) bad_burst++;
        n = (v.short_n >= 0 && v.short_n < int'(len)) ? v.short_n : int'(len);
        for (int i = 0; i < n; i++) begin
          key = (addr + 32'(i)) & 32'h07FF_FFFF;
          d = mem.exists(key) ? mem[key] : 64'h0;
          if (ri == v.flip) d = d ^ 64'h20;
          rd_burst_data = d; rd_burst_data_valid = 1;
          stop = (nr == v.stop_rd - 1 && i == 2);
          @(negedge ACLK);
          ri++;
        end
        ri += int'(len) - n;
        rd_burst_data_valid = 0; stop = 0; rd_burst_finish = 1;
        @(negedge ACLK);
        rd_burst_finish = 0; nr++;
      end
      @(negedge ACLK);
    end
  endtask

  task automatic pass_checks(input string tag, input vec_t v);
    check({tag, " finished"}, 64'(ok), 64'd1);
    check({tag, " wr_bursts"}, 64'(nw), 64'(v.exp_nb));
    check({tag, " rd_bursts"}, 64'(nr), 64'(v.exp_nb));
    check({tag, " burst_fields_bad"}, 64'(bad_burst), 64'd0);
    check({tag, " wdata_bad"}, 64'(bad_wdata), 64'd0);
    check({tag, " err_cnt"}, 64'(err_cnt), 64'(v.exp_err));
    check({tag, " error"}, 64'(error), 64'(v.exp_err != 0));
    check({tag, " loop_cnt"}, 64'(loop_cnt), 64'(v.exp_loop));
    check({tag, " done_pulses"}, 64'(dones), 64'(v.exp_done));
    check({tag, " busy"}, 64'(busy), 64'd0);
`ifdef MEM_TEST_ERR_CAPTURE_EN
    if (v.flip >= 0) begin
      check({tag, " err_addr"}, 64'(err_addr), 64'(v.base + 27'(v.flip)));
      check({tag, " err_exp"}, err_exp, model_word(v.mode, v.flip, v.base));
      check({tag, " err_got"}, err_got, model_word(v.mode, v.flip, v.base) ^ 64'h20);
    end
    if (v.short_n >= 0) begin
      check({tag, " err_addr"}, 64'(err_addr), 64'(v.base + 27'(v.short_n)));
      check({tag, " err_got"}, err_got, 64'd0);
    end
`endif
  endtask

  initial begin
    vec_t v;
    int eb;
    tbl[0] = '{0, 27'h100,     512, 128,  0, -1, -1, 0, 4, 0, 1, 1};
    tbl[1] = '{1, 27'h40,      300, 128,  0, -1, -1, 0, 3, 0, 1, 1};
    tbl[2] = '{3, 27'h2000,    64,  16,   0, 10, -1, 0, 4, 1, 1, 1};
    tbl[3] = '{2, 27'h0,       64,  64,   0, -1, 60, 0, 1, 4, 1, 1};
    tbl[4] = '{2, 27'h10,      64,  64,   1, -1, -1, 3, 3, 0, 2, 0};
    tbl[5] = '{0, 27'h7FFFFFE, 4,   2,    0, -1, -1, 0, 2, 0, 1, 1};
    tbl[6] = '{3, 27'h5,       0,   0,    0, -1, -1, 0, 1, 0, 1, 1};
    tbl[7] = '{1, 27'h300,     300, 1000, 0, -1, -1, 0, 2, 0, 1, 1};

    repeat (2) @(negedge ACLK);
    check("reset busy", 64'(busy), 0);
    check("reset done", 64'(done), 0);
    check("reset wr_req", 64'(wr_burst_req), 0);
    check("reset rd_req", 64'(rd_burst_req), 0);
    check("reset err_cnt", 64'(err_cnt), 0);
    check("reset loop_cnt", 64'(loop_cnt), 0);
    check("reset wr_data", wr_burst_data, 0);
    ARESETN = 1;

    for (int i = 0; i < 8; i++) begin
      run_pass(tbl[i]);
      pass_checks($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset pulled mid-write: everything must drop without waiting for a clock edge
    @(negedge ACLK);
    mode = 0; region_base = 27'h500; region_words = 64; burst_words = 32; continuous = 0;
    start = 1;
    @(negedge ACLK);
    start = 0;
    for (int c = 0; c < 20 && !wr_burst_req; c++) @(negedge ACLK);
    check("rst_mid wr_req_seen", 64'(wr_burst_req), 1);
    wr_burst_data_req = 1;
    repeat (3) @(negedge ACLK);
    #2 ARESETN = 0;
    #1;
    check("rst_mid wr_req", 64'(wr_burst_req), 0);
    check("rst_mid busy", 64'(busy), 0);
    check("rst_mid wr_addr", 64'(wr_burst_addr), 0);
    check("rst_mid wr_len", 64'(wr_burst_len), 0);
    check("rst_mid wr_data", wr_burst_data, 0);
    wr_burst_data_req = 0;
    @(negedge ACLK);
    ARESETN = 1;
    run_pass(tbl[0]);
    pass_checks("rst_mid fresh", tbl[0]);

    for (int r = 0; r < 6; r++) begin
      v.mode = int'($urandom_range(0, 3));
      v.base = 27'($urandom);
      v.words = int'($urandom_range(1, 150));
      v.burst = int'($urandom_range(0, 300));
      v.cont = 0;
      v.flip = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, v.words - 1)) : -1;
      v.short_n = -1; v.stop_rd = 0;
      eb = (v.burst == 0) ? 1 : ((v.burst > 256) ? 256 : v.burst);
      v.exp_nb = (v.words + eb - 1) / eb;
      v.exp_err = (v.flip >= 0) ? 1 : 0;
      v.exp_loop = 1; v.exp_done = 1;
      run_pass(v);
      pass_checks($sformatf("rand%0d", r), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
